// File: rtl/ram_dp_stream_fifo_pkg.sv
// Shared sizing constants for the RAM-backed stream FIFO and its output buffer.
package ram_dp_stream_fifo_pkg;
  localparam int FIFO_AW    = 10;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int FIFO_WIDTH = 32;
  localparam int OB_CNT_W   = 2;
  localparam int LEVEL_W    = FIFO_AW + 1;
endpackage

// File: rtl/ram_dp_stream_obuf.sv
// Two-entry output skid buffer fed by RAM read data; head is presented from a register.
// Capture and pop may coincide; occupancy never exceeds two because the parent limits reads in flight.
module ram_dp_stream_obuf
  import ram_dp_stream_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                cap,
  input  logic [WIDTH-1:0]    cap_data,
  input  logic                pop,
  output logic                valid,
  output logic [WIDTH-1:0]    head_data,
  output logic [OB_CNT_W-1:0] cnt
);

  logic [WIDTH-1:0]    ent0;
  logic [WIDTH-1:0]    ent1;
  logic                head;
  logic                tail;
  logic [OB_CNT_W-1:0] cnt_q;
  logic                pop_ok;

  assign valid     = (cnt_q != '0);
  assign pop_ok    = pop & valid;
  assign head_data = head ? ent1 : ent0;
  assign cnt       = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      cnt_q <= '0;
    end else if (clr) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (cap) begin
        if (tail) ent1 <= cap_data;
        else      ent0 <= cap_data;
        tail <= ~tail;
      end
      if (pop_ok) head <= ~head;
      cnt_q <= cnt_q + OB_CNT_W'(cap) - OB_CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/ram_dp_stream_fifo.sv
// Stream FIFO over an external dual-port RAM (A write, B registered-address read); 2-cycle empty latency.
// in_ready drops only on full or clr and never depends combinationally on out_ready.
module ram_dp_stream_fifo
  import ram_dp_stream_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int AW    = FIFO_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic             weA,
  output logic [AW-1:0]    addrA,
  output logic [WIDTH-1:0] dinA,
  output logic             weB,
  output logic [AW-1:0]    addrB,
  input  logic [WIDTH-1:0] doutB
);

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [AW:0]         ram_cnt;
  logic [AW:0]         lvl;
  logic                inflight;
  logic                live;
  logic                push;
  logic                pop;
  logic                issue;
  logic [2:0]          pend;
  logic [OB_CNT_W-1:0] ob_cnt;

  assign ram_cnt = wr_ptr - rd_ptr;
  assign lvl     = ram_cnt + (AW+1)'(inflight) + (AW+1)'(ob_cnt);
  assign level   = lvl;

  // level never exceeds 2**AW, so its top bit alone marks full; live holds in_ready low until the first clocked edge out of reset.
  assign in_ready = live & ~lvl[AW] & ~clr;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready & ~clr;

  // Counting this cycle's pop as a free slot lets reads issue every cycle while streaming.
  assign pend  = 3'(ob_cnt) + 3'(inflight);
  assign issue = (ram_cnt != '0) & (pend < (3'(2) + 3'(pop))) & ~clr;

  assign weA   = push;
  assign addrA = wr_ptr[AW-1:0];
  assign dinA  = push ? in_data : '0;
  assign weB   = 1'b0;
  assign addrB = rd_ptr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        inflight <= 1'b0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + (AW+1)'(1);
        if (issue) rd_ptr <= rd_ptr + (AW+1)'(1);
        inflight <= issue;
      end
    end
  end

  ram_dp_stream_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cap       (inflight & ~clr),
    .cap_data  (doutB),
    .pop       (pop),
    .valid     (out_valid),
    .head_data (out_data),
    .cnt       (ob_cnt)
  );

endmodule
